// File: rtl/pwr_domain_sequencer.sv
// Power-domain on/off sequencer: one domain at a time, round-robin granted.
// Down: clock gate -> isolate -> save -> switch off -> settle. Up runs the reverse order.
module pwr_domain_sequencer #(
   parameter int unsigned NUM_DOMAINS = 8,
   parameter logic [NUM_DOMAINS-1:0] ALWAYS_ON_MASK = NUM_DOMAINS'(1),
   parameter int unsigned CLK_GATE_CYCLES = 4,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_DOMAINS-1:0]         domain_req_on,
   input  logic [NUM_DOMAINS-1:0]         pwr_good,
   input  logic                           ret_ack,
   input  logic                           err_clr,
   output logic [NUM_DOMAINS-1:0]         domain_power_enable,
   output logic [NUM_DOMAINS-1:0]         domain_clock_enable,
   output logic [NUM_DOMAINS-1:0]         domain_iso_en,
   output logic                           ret_save,
   output logic                           ret_restore,
   output logic [$clog2(NUM_DOMAINS)-1:0] ret_sel,
   output logic [NUM_DOMAINS-1:0]         domain_on_status,
   output logic                           busy,
   output logic                           timeout_err,
   output logic [NUM_DOMAINS-1:0]         fault_mask
);
   localparam int unsigned IW = $clog2(NUM_DOMAINS);

   typedef enum logic [3:0] {
      IDLE, DN_CLK, DN_ISO, DN_SAVE, DN_PWR, UP_PWR, UP_RST, UP_ISO, UP_CLK, DONE
   } state_e;

   state_e                 state_q, state_d;
   logic [IW-1:0]          dom_q, dom_d, ptr_q, ptr_d, sel_q, sel_d, gnt;
   logic [15:0]            cnt_q, cnt_d;
   logic [NUM_DOMAINS-1:0] pwr_en_q, pwr_en_d, clk_en_q, clk_en_d, iso_q, iso_d;
   logic [NUM_DOMAINS-1:0] stat_q, stat_d, fault_q, fault_d, elig;
   logic                   save_q, save_d, rest_q, rest_d, busy_q, busy_d;
   logic                   terr_q, terr_d, gnt_vld, tmo;

   assign elig = ~ALWAYS_ON_MASK & ~fault_q & (domain_req_on ^ stat_q);
   assign tmo  = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

   // Round-robin: search starts one past the last granted index.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         if (!gnt_vld && elig[IW'((int'(ptr_q) + 1 + i) % NUM_DOMAINS)]) begin
            gnt_vld = 1'b1;
            gnt     = IW'((int'(ptr_q) + 1 + i) % NUM_DOMAINS);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      dom_d    = dom_q;
      ptr_d    = ptr_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q + 16'd1;
      pwr_en_d = pwr_en_q;
      clk_en_d = clk_en_q;
      iso_d    = iso_q;
      stat_d   = stat_q;
      save_d   = 1'b0;
      rest_d   = 1'b0;
      terr_d   = terr_q && !err_clr;
      fault_d  = err_clr ? '0 : fault_q;
      unique case (state_q)
         IDLE: if (gnt_vld) begin
            dom_d = gnt;
            ptr_d = gnt;
            sel_d = gnt;
            if (stat_q[gnt]) begin
               state_d       = DN_CLK;
               clk_en_d[gnt] = 1'b0;
            end else begin
               state_d       = UP_PWR;
               pwr_en_d[gnt] = 1'b1;
            end
         end
         DN_CLK: if (cnt_q == 16'(CLK_GATE_CYCLES - 1)) begin
            state_d      = DN_ISO;
            iso_d[dom_q] = 1'b1;
         end
         DN_ISO: begin
            state_d = DN_SAVE;
            save_d  = 1'b1;
         end
         // A missing save ack still powers down; the retained state is lost.
         DN_SAVE: if (ret_ack || tmo) begin
            if (!ret_ack) terr_d = 1'b1;
            state_d         = DN_PWR;
            pwr_en_d[dom_q] = 1'b0;
         end
         DN_PWR: if (cnt_q == 16'(SETTLE_CYCLES - 1)) state_d = DONE;
         UP_PWR: begin
            if (pwr_good[dom_q]) begin
               state_d = UP_RST;
               rest_d  = 1'b1;
            end else if (tmo) begin
               state_d         = IDLE;
               pwr_en_d[dom_q] = 1'b0;
               fault_d[dom_q]  = 1'b1;
               terr_d          = 1'b1;
            end
         end
         UP_RST: if (ret_ack || tmo) begin
            if (!ret_ack) terr_d = 1'b1;
            state_d      = UP_ISO;
            iso_d[dom_q] = 1'b0;
         end
         UP_ISO: begin
            state_d         = UP_CLK;
            clk_en_d[dom_q] = 1'b1;
         end
         UP_CLK: state_d = DONE;
         DONE: begin
            state_d       = IDLE;
            stat_d[dom_q] = ~stat_q[dom_q];
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         dom_q    <= '0;
         ptr_q    <= IW'(NUM_DOMAINS - 1);
         sel_q    <= '0;
         cnt_q    <= '0;
         pwr_en_q <= '1;
         clk_en_q <= '1;
         iso_q    <= '0;
         stat_q   <= '1;
         save_q   <= 1'b0;
         rest_q   <= 1'b0;
         busy_q   <= 1'b0;
         terr_q   <= 1'b0;
         fault_q  <= '0;
      end else begin
         state_q  <= state_d;
         dom_q    <= dom_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         pwr_en_q <= pwr_en_d;
         clk_en_q <= clk_en_d;
         iso_q    <= iso_d;
         stat_q   <= stat_d;
         save_q   <= save_d;
         rest_q   <= rest_d;
         busy_q   <= busy_d;
         terr_q   <= terr_d;
         fault_q  <= fault_d;
      end
   end

   assign domain_power_enable = pwr_en_q;
   assign domain_clock_enable = clk_en_q;
   assign domain_iso_en       = iso_q;
   assign ret_save            = save_q;
   assign ret_restore         = rest_q;
   assign ret_sel             = sel_q;
   assign domain_on_status    = stat_q;
   assign busy                = busy_q;
   assign timeout_err         = terr_q;
   assign fault_mask          = fault_q;

endmodule

// File: tb/tb_pwr_domain_sequencer.sv
// Scoreboard bench: stimulus queues expected output snapshots plus inter-event gaps;
// the monitor pops one entry every time any DUT output changes.
module tb_pwr_domain_sequencer;
   localparam int N = 8;

   typedef struct packed {
      logic [N-1:0] pwr, clk, iso, stat, flt;
      logic         sv, rs, bz, te;
      logic [2:0]   sel;
   } snap_t;

   logic         clk = 1'b0, rst_n = 1'b1;
   logic [N-1:0] domain_req_on = '1, pwr_good = '1;
   logic         ret_ack = 1'b0, err_clr = 1'b0;
   logic [N-1:0] domain_power_enable, domain_clock_enable, domain_iso_en;
   logic [N-1:0] domain_on_status, fault_mask;
   logic         ret_save, ret_restore, busy, timeout_err;
   logic [2:0]   ret_sel;

   logic         ack_en = 1'b0;
   logic [N-1:0] stuck = '0;
   snap_t        exp_q[$];
   int           gap_q[$];
   snap_t        m;
   int           n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   pwr_domain_sequencer dut (
      .clk(clk), .rst_n(rst_n), .domain_req_on(domain_req_on), .pwr_good(pwr_good),
      .ret_ack(ret_ack), .err_clr(err_clr), .domain_power_enable(domain_power_enable),
      .domain_clock_enable(domain_clock_enable), .domain_iso_en(domain_iso_en),
      .ret_save(ret_save), .ret_restore(ret_restore), .ret_sel(ret_sel),
      .domain_on_status(domain_on_status), .busy(busy), .timeout_err(timeout_err),
      .fault_mask(fault_mask)
   );

   function automatic string fmt(input snap_t s);
      return $sformatf("pwr=%h clk=%h iso=%h st=%h flt=%h sv=%b rs=%b bz=%b te=%b sel=%0d",
                       s.pwr, s.clk, s.iso, s.stat, s.flt, s.sv, s.rs, s.bz, s.te, s.sel);
   endfunction

   task automatic push(input int gap);
      exp_q.push_back(m);
      gap_q.push_back(gap);
   endtask

   task automatic reset_model();
      m = '0;
      m.pwr = '1; m.clk = '1; m.stat = '1;
   endtask

   task automatic down_seq(input int d, input int first_gap);
      m.clk[d] = 1'b0; m.bz = 1'b1; m.sel = 3'(d); push(first_gap);
      m.iso[d] = 1'b1; push(4);
      m.sv = 1'b1; push(1);
      m.sv = 1'b0; push(1);
      m.pwr[d] = 1'b0; push(2);
      m.stat[d] = 1'b0; m.bz = 1'b0; push(17);
   endtask

   task automatic up_seq(input int d, input int first_gap);
      m.pwr[d] = 1'b1; m.bz = 1'b1; m.sel = 3'(d); push(first_gap);
      m.rs = 1'b1; push(5);
      m.rs = 1'b0; push(1);
      m.iso[d] = 1'b0; push(2);
      m.clk[d] = 1'b1; push(1);
      m.stat[d] = 1'b1; m.bz = 1'b0; push(2);
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout: %0d events outstanding after %0d cycles, want 0",
                  exp_q.size(), budget);
         exp_q.delete();
         gap_q.delete();
      end
   endtask

   // Rail model: pwr_good rises 5 cycles after power is enabled unless stuck.
   initial begin
      int pgc [N];
      for (int d = 0; d < N; d++) pgc[d] = 5;
      forever begin
         @(negedge clk);
         for (int d = 0; d < N; d++) begin
            if (!domain_power_enable[d] || stuck[d]) begin
               pgc[d] = 0;
               pwr_good[d] = 1'b0;
            end else begin
               if (pgc[d] < 5) pgc[d]++;
               if (pgc[d] >= 5) pwr_good[d] = 1'b1;
            end
         end
      end
   end

   // Retention controller: acks two cycles after a save/restore pulse.
   initial begin
      forever begin
         @(negedge clk);
         if (ack_en && (ret_save || ret_restore)) begin
            repeat (2) @(negedge clk);
            ret_ack = 1'b1;
            @(negedge clk);
            ret_ack = 1'b0;
         end
      end
   end

   // Monitor
   initial begin
      snap_t cur, prev, es;
      int    eg, cyc, last;
      bit    first;
      cyc = 0; last = 0; first = 1'b1; prev = '0;
      forever begin
         @(negedge clk);
         cyc++;
         cur.pwr = domain_power_enable; cur.clk = domain_clock_enable;
         cur.iso = domain_iso_en;       cur.stat = domain_on_status;
         cur.flt = fault_mask;          cur.sv = ret_save;
         cur.rs = ret_restore;          cur.bz = busy;
         cur.te = timeout_err;          cur.sel = ret_sel;
         if (first || cur != prev) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_event cyc %0d: got %s, want no change", cyc, fmt(cur));
            end else begin
               es = exp_q.pop_front();
               eg = gap_q.pop_front();
               if (cur !== es) begin
                  n_err++;
                  $display("FAIL snapshot cyc %0d: got %s, want %s", cyc, fmt(cur), fmt(es));
               end
               if (eg >= 0) begin
                  n_cmp++;
                  if (cyc - last != eg) begin
                     n_err++;
                     $display("FAIL gap cyc %0d: got %0d cycles, want %0d", cyc, cyc - last, eg);
                  end
               end
            end
            n_cmp++;
            if ((cur.clk & (cur.iso | ~cur.pwr)) != '0) begin
               n_err++;
               $display("FAIL clk_order cyc %0d: got clk=%h iso=%h pwr=%h, want no clock on isolated/unpowered domain",
                        cyc, cur.clk, cur.iso, cur.pwr);
            end
            prev = cur; last = cyc; first = 1'b0;
         end
      end
   end

   initial begin
      // Reset state, then all domains already at target: nothing should move.
      reset_model(); push(-1);
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ack_en = 1'b1;
      wait_drain(10);
      repeat (10) @(negedge clk);

      // Domain 3 off, then back on.
      down_seq(3, -1);
      @(negedge clk); domain_req_on[3] = 1'b0;
      wait_drain(100);
      repeat (3) @(negedge clk);
      up_seq(3, -1);
      @(negedge clk); domain_req_on[3] = 1'b1;
      wait_drain(100);
      repeat (3) @(negedge clk);

      // Reset while domain 6 waits in DN_SAVE (no ack), then restart from DN_CLK.
      ack_en = 1'b0;
      m.clk[6] = 1'b0; m.bz = 1'b1; m.sel = 3'd6; push(-1);
      m.iso[6] = 1'b1; push(4);
      m.sv = 1'b1; push(1);
      m.sv = 1'b0; push(1);
      @(negedge clk); domain_req_on[6] = 1'b0;
      wait_drain(50);
      repeat (5) @(negedge clk);
      reset_model(); push(-1);
      @(posedge clk); #2 rst_n = 1'b0;
      wait_drain(5);
      repeat (2) @(negedge clk);
      down_seq(6, -1);
      ack_en = 1'b1;
      rst_n = 1'b1;
      wait_drain(100);
      repeat (3) @(negedge clk);

      // Domains 2 and 5 together: 2 first, 5 granted one cycle after 2 commits; 0 ignored.
      down_seq(2, -1);
      down_seq(5, 1);
      @(negedge clk); domain_req_on[2] = 1'b0; domain_req_on[5] = 1'b0;
      repeat (2) @(negedge clk); domain_req_on[0] = 1'b0;
      wait_drain(150);
      repeat (5) @(negedge clk);

      // Domain 4: off, then power-up with stuck rail -> timeout, fault, no re-grant.
      down_seq(4, -1);
      @(negedge clk); domain_req_on[4] = 1'b0;
      wait_drain(100);
      repeat (3) @(negedge clk);
      stuck[4] = 1'b1;
      m.pwr[4] = 1'b1; m.bz = 1'b1; m.sel = 3'd4; push(-1);
      m.pwr[4] = 1'b0; m.flt[4] = 1'b1; m.te = 1'b1; m.bz = 1'b0; push(256);
      @(negedge clk); domain_req_on[4] = 1'b1;
      wait_drain(400);
      repeat (20) @(negedge clk);

      // err_clr clears flags; domain 4 is re-granted the cycle after.
      stuck[4] = 1'b0;
      m.flt = '0; m.te = 1'b0; push(-1);
      up_seq(4, 1);
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      wait_drain(100);
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, want finish");
      $fatal(1);
   end
endmodule
